// File: rtl/neuron_mult_scheduler.sv
// Round-robin scheduler that time-shares one combinational float multiplier among NREQ requesters.
// One operation in flight: accept a winner, hold its operands MULT_LAT cycles, capture, return via valid/ready.
module neuron_mult_scheduler #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MULT_LAT = 1
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic [NREQ-1:0]     ReqVec,
  input  logic [NREQ-1:0]     SignAIn,
  input  logic [NREQ-1:0]     SignBIn,
  input  logic [5*NREQ-1:0]   ExponentAIn,
  input  logic [5*NREQ-1:0]   ExponentBIn,
  input  logic [6*NREQ-1:0]   MantissaAIn,
  input  logic [6*NREQ-1:0]   MantissaBIn,
  output logic [NREQ-1:0]     GntVec,
  output logic                Busy,
  output logic                SignA,
  output logic                SignB,
  output logic [4:0]          ExponentA,
  output logic [4:0]          ExponentB,
  output logic [5:0]          MantissaA,
  output logic [5:0]          MantissaB,
  input  logic                SignOut,
  input  logic [5:0]          ExponentOut,
  input  logic                ExponentC,
  input  logic [11:0]         MantissaOut,
  output logic                RespValid,
  input  logic                RespReady,
  output logic [IDW-1:0]      RespId,
  output logic                RespSign,
  output logic [5:0]          RespExponent,
  output logic                RespExponentC,
  output logic [11:0]         RespMantissa
);

  localparam int CNTW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e          state_q;
  logic [IDW-1:0]  last_q;
  logic [CNTW-1:0] cnt_q;
  logic            op_sa_q, op_sb_q;
  logic [4:0]      op_ea_q, op_eb_q;
  logic [5:0]      op_ma_q, op_mb_q;
  logic            resp_vld_q;
  logic [IDW-1:0]  resp_id_q;
  logic            resp_sign_q, resp_c_q;
  logic [5:0]      resp_exp_q;
  logic [11:0]     resp_man_q;

  logic [IDW-1:0]  win_idx_d;
  logic            win_vld_d;
  logic [IDW-1:0]  cand_d;

  logic [4:0] exp_a [NREQ];
  logic [4:0] exp_b [NREQ];
  logic [5:0] man_a [NREQ];
  logic [5:0] man_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign exp_a[i] = ExponentAIn[5*i +: 5];
    assign exp_b[i] = ExponentBIn[5*i +: 5];
    assign man_a[i] = MantissaAIn[6*i +: 6];
    assign man_b[i] = MantissaBIn[6*i +: 6];
  end

  // Scan from farthest to nearest so the first requester after last_q ends up as winner.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand_d    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_d = IDW'((int'(last_q) + k) % NREQ);
      if (ReqVec[cand_d]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d;
      end
    end
  end

  assign GntVec = (state_q == ST_IDLE && win_vld_d) ? (NREQ'(1) << win_idx_d) : '0;
  assign Busy   = (state_q != ST_IDLE);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      op_sa_q     <= 1'b0;
      op_sb_q     <= 1'b0;
      op_ea_q     <= '0;
      op_eb_q     <= '0;
      op_ma_q     <= '0;
      op_mb_q     <= '0;
      resp_vld_q  <= 1'b0;
      resp_id_q   <= '0;
      resp_sign_q <= 1'b0;
      resp_c_q    <= 1'b0;
      resp_exp_q  <= '0;
      resp_man_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            op_sa_q   <= SignAIn[win_idx_d];
            op_sb_q   <= SignBIn[win_idx_d];
            op_ea_q   <= exp_a[win_idx_d];
            op_eb_q   <= exp_b[win_idx_d];
            op_ma_q   <= man_a[win_idx_d];
            op_mb_q   <= man_b[win_idx_d];
            resp_id_q <= win_idx_d;
            last_q    <= win_idx_d;
            cnt_q     <= CNTW'(MULT_LAT - 1);
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNTW'(1);
          end else begin
            resp_sign_q <= SignOut;
            resp_exp_q  <= ExponentOut;
            resp_c_q    <= ExponentC;
            resp_man_q  <= MantissaOut;
            resp_vld_q  <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_vld_q && RespReady) begin
            resp_vld_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SignA         = op_sa_q;
  assign SignB         = op_sb_q;
  assign ExponentA     = op_ea_q;
  assign ExponentB     = op_eb_q;
  assign MantissaA     = op_ma_q;
  assign MantissaB     = op_mb_q;
  assign RespValid     = resp_vld_q;
  assign RespId        = resp_id_q;
  assign RespSign      = resp_sign_q;
  assign RespExponent  = resp_exp_q;
  assign RespExponentC = resp_c_q;
  assign RespMantissa  = resp_man_q;

endmodule

// File: tb/tb_neuron_mult_scheduler.sv
// Directed plus randomized bench for neuron_mult_scheduler; a MULT_LAT=3 instance covers the longer settle window.
module tb_neuron_mult_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int EW   = 5 * NREQ;
  localparam int MW   = 6 * NREQ;

  logic Clk = 1'b0;
  logic ResetN;
  always #5 Clk = ~Clk;

  logic [NREQ-1:0] ReqVec, ReqVec3, SignAIn, SignBIn;
  logic [EW-1:0]   ExponentAIn, ExponentBIn;
  logic [MW-1:0]   MantissaAIn, MantissaBIn;
  logic            RespReady, RespReady3;

  logic [NREQ-1:0] GntVec, GntVec3;
  logic            Busy, Busy3, SignA, SignA3, SignB, SignB3;
  logic [4:0]      ExponentA, ExponentA3, ExponentB, ExponentB3;
  logic [5:0]      MantissaA, MantissaA3, MantissaB, MantissaB3;
  logic            SignOut, SignOut3, ExponentC, ExponentC3;
  logic [5:0]      ExponentOut, ExponentOut3;
  logic [11:0]     MantissaOut, MantissaOut3;
  logic            RespValid, RespValid3;
  logic [IDW-1:0]  RespId, RespId3;
  logic            RespSign, RespSign3, RespExponentC, RespExponentC3;
  logic [5:0]      RespExponent, RespExponent3;
  logic [11:0]     RespMantissa, RespMantissa3;

  // Behavioural stand-in for the shared multiplier
  assign SignOut      = SignA ^ SignB;
  assign ExponentOut  = {1'b0, ExponentA} + {1'b0, ExponentB};
  assign ExponentC    = (ExponentOut > 6'd30);
  assign MantissaOut  = {6'b0, MantissaA} * {6'b0, MantissaB};
  assign SignOut3     = SignA3 ^ SignB3;
  assign ExponentOut3 = {1'b0, ExponentA3} + {1'b0, ExponentB3};
  assign ExponentC3   = (ExponentOut3 > 6'd30);
  assign MantissaOut3 = {6'b0, MantissaA3} * {6'b0, MantissaB3};

  neuron_mult_scheduler #(.NREQ(NREQ), .IDW(IDW), .MULT_LAT(1)) dut (
    .Clk(Clk), .ResetN(ResetN), .ReqVec(ReqVec), .SignAIn(SignAIn), .SignBIn(SignBIn),
    .ExponentAIn(ExponentAIn), .ExponentBIn(ExponentBIn),
    .MantissaAIn(MantissaAIn), .MantissaBIn(MantissaBIn),
    .GntVec(GntVec), .Busy(Busy), .SignA(SignA), .SignB(SignB),
    .ExponentA(ExponentA), .ExponentB(ExponentB), .MantissaA(MantissaA), .MantissaB(MantissaB),
    .SignOut(SignOut), .ExponentOut(ExponentOut), .ExponentC(ExponentC), .MantissaOut(MantissaOut),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId), .RespSign(RespSign),
    .RespExponent(RespExponent), .RespExponentC(RespExponentC), .RespMantissa(RespMantissa)
  );

  neuron_mult_scheduler #(.NREQ(NREQ), .IDW(IDW), .MULT_LAT(3)) dut3 (
    .Clk(Clk), .ResetN(ResetN), .ReqVec(ReqVec3), .SignAIn(SignAIn), .SignBIn(SignBIn),
    .ExponentAIn(ExponentAIn), .ExponentBIn(ExponentBIn),
    .MantissaAIn(MantissaAIn), .MantissaBIn(MantissaBIn),
    .GntVec(GntVec3), .Busy(Busy3), .SignA(SignA3), .SignB(SignB3),
    .ExponentA(ExponentA3), .ExponentB(ExponentB3), .MantissaA(MantissaA3), .MantissaB(MantissaB3),
    .SignOut(SignOut3), .ExponentOut(ExponentOut3), .ExponentC(ExponentC3), .MantissaOut(MantissaOut3),
    .RespValid(RespValid3), .RespReady(RespReady3), .RespId(RespId3), .RespSign(RespSign3),
    .RespExponent(RespExponent3), .RespExponentC(RespExponentC3), .RespMantissa(RespMantissa3)
  );

  int checks   = 0;
  int failures = 0;
  int last_srv;

  logic [IDW-1:0] e_id;
  logic           e_sa, e_sb, e_sign, e_c;
  logic [4:0]     e_ea, e_eb;
  logic [5:0]     e_ma, e_mb, e_exp;
  logic [11:0]    e_man;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
    int n;
    for (int k = 1; k <= NREQ; k++) begin
      n = (last + k) % NREQ;
      if (req[n[IDW-1:0]]) return n;
    end
    return -1;
  endfunction

  task automatic rand_ops();
    SignAIn     = NREQ'($urandom);
    SignBIn     = NREQ'($urandom);
    ExponentAIn = EW'($urandom);
    ExponentBIn = EW'($urandom);
    MantissaAIn = MW'($urandom);
    MantissaBIn = MW'($urandom);
  endtask

  task automatic capture_exp(input int w);
    e_id   = w[IDW-1:0];
    e_sa   = SignAIn[w[IDW-1:0]];
    e_sb   = SignBIn[w[IDW-1:0]];
    e_ea   = ExponentAIn[5*w +: 5];
    e_eb   = ExponentBIn[5*w +: 5];
    e_ma   = MantissaAIn[6*w +: 6];
    e_mb   = MantissaBIn[6*w +: 6];
    e_sign = e_sa ^ e_sb;
    e_exp  = {1'b0, e_ea} + {1'b0, e_eb};
    e_c    = (e_exp > 6'd30);
    e_man  = {6'b0, e_ma} * {6'b0, e_mb};
  endtask

  // One transaction on the MULT_LAT=1 instance; inputs change right after each rising edge.
  task automatic run_txn(input logic [NREQ-1:0] req, input bit hold, input int stall,
                         input logic [NREQ-1:0] pulse);
    int w;
    logic [NREQ-1:0] e_gnt;
    ReqVec    = req;
    RespReady = (stall == 0);
    w = rr_pick(req, last_srv);
    e_gnt = (w < 0) ? '0 : (NREQ'(1) << w);
    @(negedge Clk);
    chk("idle_rvalid", RespValid, 1'b0);
    chk("idle_busy", Busy, 1'b0);
    chk("grant", GntVec, e_gnt);
    if (w < 0) begin
      @(posedge Clk); #1;
      return;
    end
    capture_exp(w);
    @(posedge Clk); #1;
    last_srv = w;
    if (!hold) ReqVec = req & ~e_gnt;
    ReqVec = ReqVec | pulse;
    rand_ops();
    @(negedge Clk);
    chk("wait_busy", Busy, 1'b1);
    chk("wait_gnt", GntVec, '0);
    chk("wait_rvalid", RespValid, 1'b0);
    chk("op_sign_a", SignA, e_sa);
    chk("op_sign_b", SignB, e_sb);
    chk("op_exp_a", ExponentA, e_ea);
    chk("op_exp_b", ExponentB, e_eb);
    chk("op_man_a", MantissaA, e_ma);
    chk("op_man_b", MantissaB, e_mb);
    @(posedge Clk); #1;
    ReqVec = ReqVec & ~pulse;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) RespReady = 1'b1;
      @(negedge Clk);
      chk("resp_valid", RespValid, 1'b1);
      chk("resp_gnt", GntVec, '0);
      chk("resp_id", RespId, e_id);
      chk("resp_sign", RespSign, e_sign);
      chk("resp_exp", RespExponent, e_exp);
      chk("resp_expc", RespExponentC, e_c);
      chk("resp_man", RespMantissa, e_man);
      chk("resp_op_hold", MantissaA, e_ma);
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    ResetN = 1'b0; ReqVec = '0; ReqVec3 = '0; RespReady = 1'b0; RespReady3 = 1'b0;
    rand_ops();
    last_srv = NREQ - 1;
    @(negedge Clk);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_rvalid", RespValid, 1'b0);
    chk("rst_gnt", GntVec, '0);
    chk("rst_man_a", MantissaA, 6'd0);
    chk("rst_resp_man", RespMantissa, 12'd0);
    @(posedge Clk); #1;
    ResetN = 1'b1;

    // Directed single request from requester 2
    rand_ops();
    SignAIn[2] = 1'b1; SignBIn[2] = 1'b0;
    ExponentAIn[14:10] = 5'd3; ExponentBIn[14:10] = 5'd6;
    MantissaAIn[17:12] = 6'd7; MantissaBIn[17:12] = 6'd9;
    run_txn(4'b0100, 1'b0, 0, '0);
    chk("t1_id", RespId, 2'd2);
    chk("t1_sign", RespSign, 1'b1);
    chk("t1_man", RespMantissa, 12'd63);
    chk("t1_exp", RespExponent, 6'd9);
    chk("t1_expc", RespExponentC, 1'b0);
    chk("t1_op_ea", ExponentA, 5'd3);
    chk("t1_op_mb", MantissaB, 6'd9);

    // All requests held: rotation continues from requester 2's grant
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      run_txn(4'b1111, 1'b1, 0, '0);
    end

    // Backpressure for 5 cycles
    rand_ops();
    run_txn(4'b1000, 1'b0, 5, '0);

    // Requester 1 pulses only while another operation is in flight
    rand_ops();
    run_txn(4'b0100, 1'b0, 0, 4'b0010);
    rand_ops();
    run_txn(4'b0001, 1'b0, 0, '0);

    // Reset in WAIT discards the operation and restarts arbitration at requester 0
    rand_ops();
    ReqVec = 4'b0010; RespReady = 1'b1;
    @(negedge Clk);
    chk("t4_gnt", GntVec, 4'b0010);
    @(posedge Clk); #1;
    ReqVec = '0;
    #2 ResetN = 1'b0;
    #1;
    chk("t4_busy", Busy, 1'b0);
    chk("t4_rvalid", RespValid, 1'b0);
    chk("t4_resp_man", RespMantissa, 12'd0);
    chk("t4_resp_exp", RespExponent, 6'd0);
    chk("t4_op_ea", ExponentA, 5'd0);
    chk("t4_op_mb", MantissaB, 6'd0);
    @(posedge Clk); #1;
    ResetN = 1'b1;
    last_srv = NREQ - 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("t4_no_resp", RespValid, 1'b0);
      @(posedge Clk); #1;
    end
    rand_ops();
    run_txn(4'b1010, 1'b0, 0, '0);
    chk("t4_first_id", RespId, 2'd1);

    // Randomized traffic
    for (int i = 0; i < 14; i++) begin
      rand_ops();
      run_txn(NREQ'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), '0);
    end
    ReqVec = '0;

    // MULT_LAT=3 instance: three WAIT cycles with operands changing on the inputs
    rand_ops();
    ReqVec3 = 4'b0001; RespReady3 = 1'b1;
    @(negedge Clk);
    chk("l3_gnt", GntVec3, 4'b0001);
    capture_exp(0);
    @(posedge Clk); #1;
    ReqVec3 = '0;
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      @(negedge Clk);
      chk("l3_wait_rvalid", RespValid3, 1'b0);
      chk("l3_wait_busy", Busy3, 1'b1);
      chk("l3_op_ma", MantissaA3, e_ma);
      chk("l3_op_eb", ExponentB3, e_eb);
      chk("l3_op_sa", SignA3, e_sa);
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    chk("l3_rvalid", RespValid3, 1'b1);
    chk("l3_id", RespId3, 2'd0);
    chk("l3_man", RespMantissa3, e_man);
    chk("l3_exp", RespExponent3, e_exp);
    chk("l3_expc", RespExponentC3, e_c);
    chk("l3_sign", RespSign3, e_sign);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("l3_done_rvalid", RespValid3, 1'b0);
    chk("l3_done_busy", Busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
